// File: rtl/ddr3_avl_arbiter_if.sv
// Requester and DDR3 Avalon-MM signal bundle for ddr3_avl_arbiter.
// master: arbiter view; slave: requesters plus controller view.
interface ddr3_avl_arbiter_if #(
   parameter int ADDR_W = 26,
   parameter int DATA_W = 64
);
   logic                rd_req;
   logic [ADDR_W-1:0]   rd_addr;
   logic                rd_urgent;
   logic                rd_ack;

   logic                wr_req;
   logic [ADDR_W-1:0]   wr_addr;
   logic [DATA_W-1:0]   wr_data;
   logic                wr_data_ack;
   logic                wr_ack;

   logic                ddr3_avl_ready;
   logic                ddr3_avl_burstbegin;
   logic                ddr3_avl_read_req;
   logic                ddr3_avl_write_req;
   logic [ADDR_W-1:0]   ddr3_avl_addr;
   logic [2:0]          ddr3_avl_size;
   logic [DATA_W-1:0]   ddr3_avl_wdata;
   logic [DATA_W/8-1:0] ddr3_avl_be;

   modport master (
      input  rd_req,
      input  rd_addr,
      input  rd_urgent,
      input  wr_req,
      input  wr_addr,
      input  wr_data,
      input  ddr3_avl_ready,
      output rd_ack,
      output wr_data_ack,
      output wr_ack,
      output ddr3_avl_burstbegin,
      output ddr3_avl_read_req,
      output ddr3_avl_write_req,
      output ddr3_avl_addr,
      output ddr3_avl_size,
      output ddr3_avl_wdata,
      output ddr3_avl_be
   );

   modport slave (
      output rd_req,
      output rd_addr,
      output rd_urgent,
      output wr_req,
      output wr_addr,
      output wr_data,
      output ddr3_avl_ready,
      input  rd_ack,
      input  wr_data_ack,
      input  wr_ack,
      input  ddr3_avl_burstbegin,
      input  ddr3_avl_read_req,
      input  ddr3_avl_write_req,
      input  ddr3_avl_addr,
      input  ddr3_avl_size,
      input  ddr3_avl_wdata,
      input  ddr3_avl_be
   );
endinterface

// File: rtl/ddr3_avl_arbiter.sv
// Two-requester DDR3 Avalon-MM arbiter: round-robin, urgent reads, write starvation bound.
// Optional statistics counters built when DDR3_ARB_STATS_EN is defined.
module ddr3_avl_arbiter #(
   parameter int ADDR_W     = 26,
   parameter int DATA_W     = 64,
   parameter int BURST_LEN  = 4,
   parameter int MAX_RD_RUN = 8
) (
   input  logic                ddr3_clk,
   input  logic                reset,
   ddr3_avl_arbiter_if.master  bus,
   output logic [31:0]         rd_grant_count,
   output logic [31:0]         wr_grant_count,
   output logic [31:0]         stall_count
);
   localparam int RUN_W = $clog2(MAX_RD_RUN + 1);
   localparam logic [2:0] LAST_BEAT = 3'(BURST_LEN - 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_RD_RUN);

   typedef enum logic [1:0] {
      IDLE,
      RD_CMD,
      WR_BURST
   } state_t;

   state_t            state, state_nxt;
   logic [2:0]        beat, beat_nxt;
   logic              last_grant, last_grant_nxt;
   logic [RUN_W-1:0]  rd_run, rd_run_nxt;

   logic              grant_rd, grant_wr;
   logic              rd_ack, wr_data_ack, wr_ack;
   logic              burstbegin, read_req, write_req;
   logic [ADDR_W-1:0] avl_addr;
   logic [DATA_W-1:0] avl_wdata;

   always_ff @(posedge ddr3_clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         beat       <= '0;
         last_grant <= 1'b1;
         rd_run     <= '0;
      end else begin
         state      <= state_nxt;
         beat       <= beat_nxt;
         last_grant <= last_grant_nxt;
         rd_run     <= rd_run_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      beat_nxt       = beat;
      last_grant_nxt = last_grant;
      rd_run_nxt     = rd_run;
      grant_rd       = 1'b0;
      grant_wr       = 1'b0;
      rd_ack         = 1'b0;
      wr_data_ack    = 1'b0;
      wr_ack         = 1'b0;
      burstbegin     = 1'b0;
      read_req       = 1'b0;
      write_req      = 1'b0;
      avl_addr       = '0;
      avl_wdata      = '0;

      unique case (state)
         IDLE: begin
            // Starvation bound outranks urgency, else urgent reads could lock out writes.
            if (bus.wr_req && rd_run == RUN_MAX)
               grant_wr = 1'b1;
            else if (bus.rd_req && bus.rd_urgent)
               grant_rd = 1'b1;
            else if (bus.rd_req && bus.wr_req) begin
               grant_rd = last_grant;
               grant_wr = ~last_grant;
            end else if (bus.rd_req)
               grant_rd = 1'b1;
            else if (bus.wr_req)
               grant_wr = 1'b1;

            if (grant_rd) begin
               state_nxt = RD_CMD;
               if (bus.wr_req && rd_run != RUN_MAX)
                  rd_run_nxt = rd_run + RUN_W'(1);
            end
            if (grant_wr) begin
               state_nxt  = WR_BURST;
               rd_run_nxt = '0;
            end
         end

         RD_CMD: begin
            read_req   = 1'b1;
            burstbegin = 1'b1;
            avl_addr   = bus.rd_addr;
            if (bus.ddr3_avl_ready) begin
               rd_ack         = 1'b1;
               last_grant_nxt = 1'b0;
               state_nxt      = IDLE;
            end
         end

         WR_BURST: begin
            write_req  = 1'b1;
            burstbegin = (beat == 3'd0);
            avl_addr   = bus.wr_addr;
            avl_wdata  = bus.wr_data;
            if (bus.ddr3_avl_ready) begin
               wr_data_ack = 1'b1;
               if (beat == LAST_BEAT) begin
                  wr_ack         = 1'b1;
                  beat_nxt       = '0;
                  last_grant_nxt = 1'b1;
                  state_nxt      = IDLE;
               end else begin
                  beat_nxt = beat + 3'd1;
               end
            end
         end

         default: begin
            state_nxt = IDLE;
            beat_nxt  = '0;
         end
      endcase
   end

   assign bus.rd_ack              = rd_ack;
   assign bus.wr_data_ack         = wr_data_ack;
   assign bus.wr_ack              = wr_ack;
   assign bus.ddr3_avl_burstbegin = burstbegin;
   assign bus.ddr3_avl_read_req   = read_req;
   assign bus.ddr3_avl_write_req  = write_req;
   assign bus.ddr3_avl_addr       = avl_addr;
   assign bus.ddr3_avl_wdata      = avl_wdata;
   assign bus.ddr3_avl_size       = 3'(BURST_LEN);
   assign bus.ddr3_avl_be         = '1;

`ifdef DDR3_ARB_STATS_EN
   logic [31:0] rd_cnt, wr_cnt, stall_cnt;

   always_ff @(posedge ddr3_clk or posedge reset) begin
      if (reset) begin
         rd_cnt    <= '0;
         wr_cnt    <= '0;
         stall_cnt <= '0;
      end else begin
         if (rd_ack)
            rd_cnt <= rd_cnt + 32'd1;
         if (wr_ack)
            wr_cnt <= wr_cnt + 32'd1;
         if ((read_req || write_req) && !bus.ddr3_avl_ready)
            stall_cnt <= stall_cnt + 32'd1;
      end
   end

   assign rd_grant_count = rd_cnt;
   assign wr_grant_count = wr_cnt;
   assign stall_count    = stall_cnt;
`else
   assign rd_grant_count = '0;
   assign wr_grant_count = '0;
   assign stall_count    = '0;
`endif

endmodule

// File: tb/tb_ddr3_avl_arbiter.sv
// Scoreboard bench for ddr3_avl_arbiter: requester drivers push expectations,
// a negedge monitor pops and compares every accepted command and beat.
module tb_ddr3_avl_arbiter;
   localparam int AW    = 26;
   localparam int DW    = 64;
   localparam int BL    = 4;
   localparam int MAXR  = 8;
   localparam int BOUND = 2000;

`ifdef DDR3_ARB_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        ddr3_clk = 1'b0;
   logic        reset    = 1'b1;
   logic [31:0] rd_grant_count, wr_grant_count, stall_count;

   ddr3_avl_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   ddr3_avl_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .MAX_RD_RUN(MAXR)
   ) dut (
      .ddr3_clk       (ddr3_clk),
      .reset          (reset),
      .bus            (bus),
      .rd_grant_count (rd_grant_count),
      .wr_grant_count (wr_grant_count),
      .stall_count    (stall_count)
   );

   always #5 ddr3_clk = ~ddr3_clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      int            idx;
   } beat_t;

   int            n_checks = 0;
   int            n_pass   = 0;
   logic [AW-1:0] exp_rd[$];
   beat_t         exp_wr[$];
   bit            exp_grant[$];

   int            rd_acks = 0, wr_acks = 0, wda_cnt = 0;
   int            bb_cycles = 0, d1_cycles = 0;
   logic [DW-1:0] d1_val = 64'h0123_4567_89AB_CDEF;

   int            rdy_mode = 0;
   int            stall_budget = 0;
   bit            stall_wr_only = 1'b0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endfunction

   function automatic void fail(string name, string what);
      n_checks++;
      $display("FAIL %s: got %s expected a response", name, what);
   endfunction

   // Ready source: 0 always ready, 1 random, 2 stall budget on commands.
   initial begin
      bus.ddr3_avl_ready = 1'b1;
      forever begin
         @(posedge ddr3_clk);
         #1;
         case (rdy_mode)
            1: bus.ddr3_avl_ready = ($urandom_range(3, 0) != 0);
            2: begin
               if (stall_budget > 0 &&
                   ((bus.ddr3_avl_write_req && !bus.ddr3_avl_burstbegin) ||
                    (!stall_wr_only &&
                     (bus.ddr3_avl_read_req || bus.ddr3_avl_write_req)))) begin
                  bus.ddr3_avl_ready = 1'b0;
                  stall_budget--;
               end else begin
                  bus.ddr3_avl_ready = 1'b1;
               end
            end
            default: bus.ddr3_avl_ready = 1'b1;
         endcase
      end
   end

   always @(negedge ddr3_clk) begin
      if (!reset) begin
         rd_acks += int'(bus.rd_ack);
         wr_acks += int'(bus.wr_ack);
         wda_cnt += int'(bus.wr_data_ack);
         if (bus.ddr3_avl_write_req && bus.ddr3_avl_burstbegin) bb_cycles++;
         if (bus.ddr3_avl_write_req && bus.ddr3_avl_wdata == d1_val) d1_cycles++;

         if (bus.ddr3_avl_read_req && bus.ddr3_avl_ready) begin
            if (exp_rd.size() == 0) fail("rd_unexpected", "an unrequested read");
            else chk("rd_addr", 64'(bus.ddr3_avl_addr), 64'(exp_rd.pop_front()));
            chk("rd_ack_bb", {bus.rd_ack, bus.ddr3_avl_burstbegin}, 2'b11);
            if (exp_grant.size() > 0) chk("grant_order", 64'(0), 64'(exp_grant.pop_front()));
         end

         if (bus.ddr3_avl_write_req && bus.ddr3_avl_ready) begin
            if (exp_wr.size() == 0) begin
               fail("wr_unexpected", "an unrequested write beat");
            end else begin
               beat_t b;
               b = exp_wr.pop_front();
               chk("wr_addr", 64'(bus.ddr3_avl_addr), 64'(b.addr));
               chk("wr_data", bus.ddr3_avl_wdata, b.data);
               chk("wr_flags",
                   {bus.ddr3_avl_burstbegin, bus.wr_ack, bus.wr_data_ack},
                   {b.idx == 0, b.idx == BL - 1, 1'b1});
               if (b.idx == 0 && exp_grant.size() > 0)
                  chk("grant_order", 64'(1), 64'(exp_grant.pop_front()));
            end
         end

         if (bus.rd_ack || bus.wr_data_ack)
            chk("ack_qual", {bus.rd_ack, bus.wr_data_ack},
                {bus.ddr3_avl_read_req && bus.ddr3_avl_ready,
                 bus.ddr3_avl_write_req && bus.ddr3_avl_ready});
      end
   end

   task automatic do_reset();
      reset         = 1'b1;
      bus.rd_req    = 1'b0;
      bus.rd_urgent = 1'b0;
      bus.rd_addr   = '0;
      bus.wr_req    = 1'b0;
      bus.wr_addr   = '0;
      bus.wr_data   = '0;
      exp_rd.delete();
      exp_wr.delete();
      exp_grant.delete();
      repeat (3) @(posedge ddr3_clk);
      @(negedge ddr3_clk);
      reset = 1'b0;
      @(posedge ddr3_clk);
      #1;
   endtask

   task automatic rd_drive(int n, int gap_max, int urg);
      for (int i = 0; i < n; i++) begin
         logic [AW-1:0] a;
         int            t;
         bit            got;
         repeat ($urandom_range(gap_max, 0)) begin
            @(posedge ddr3_clk);
            #1;
         end
         a = AW'($urandom);
         exp_rd.push_back(a);
         bus.rd_addr   = a;
         bus.rd_urgent = (urg == 2) ? ($urandom_range(2, 0) == 0) : (urg != 0);
         bus.rd_req    = 1'b1;
         t   = 0;
         got = 1'b0;
         while (!got && t < BOUND) begin
            @(negedge ddr3_clk);
            t++;
            if (bus.rd_ack) got = 1'b1;
         end
         if (!got) begin
            bus.rd_req = 1'b0;
            fail("rd_timeout", "no rd_ack");
            return;
         end
         @(posedge ddr3_clk);
         #1;
         bus.rd_req    = 1'b0;
         bus.rd_urgent = 1'b0;
      end
   endtask

   task automatic wr_drive(int n, int gap_max, logic [DW-1:0] base);
      for (int i = 0; i < n; i++) begin
         logic [AW-1:0] a;
         logic [DW-1:0] w [BL];
         int            b, t;
         repeat ($urandom_range(gap_max, 0)) begin
            @(posedge ddr3_clk);
            #1;
         end
         a = AW'($urandom);
         for (int k = 0; k < BL; k++) begin
            w[k] = (base != 0) ? base + DW'(k) : {$urandom, $urandom};
            exp_wr.push_back('{a, w[k], k});
         end
         bus.wr_addr = a;
         bus.wr_data = w[0];
         bus.wr_req  = 1'b1;
         b = 0;
         t = 0;
         while (b < BL && t < BOUND) begin
            @(negedge ddr3_clk);
            t++;
            if (bus.wr_data_ack) begin
               @(posedge ddr3_clk);
               #1;
               b++;
               if (b < BL) bus.wr_data = w[b];
            end
         end
         bus.wr_req = 1'b0;
         if (b < BL) begin
            fail("wr_timeout", "an incomplete burst");
            return;
         end
      end
   endtask

   int            s_rd, s_wr, s_wda, s_bb, s_d1, mb, mt;
   logic [DW-1:0] mw [BL];
   logic [AW-1:0] ma;

   initial begin
      bus.rd_req    = 1'b0;
      bus.rd_urgent = 1'b0;
      bus.rd_addr   = '0;
      bus.wr_req    = 1'b0;
      bus.wr_addr   = '0;
      bus.wr_data   = '0;

      // Outputs while reset is held
      @(negedge ddr3_clk);
      chk("reset_cmd", {bus.ddr3_avl_read_req, bus.ddr3_avl_write_req,
                        bus.ddr3_avl_burstbegin, bus.rd_ack, bus.wr_ack,
                        bus.wr_data_ack}, 0);
      chk("reset_addr", 64'(bus.ddr3_avl_addr), 0);
      chk("reset_wdata", bus.ddr3_avl_wdata, 0);
      chk("reset_size", 64'(bus.ddr3_avl_size), BL);
      chk("reset_be", 64'(bus.ddr3_avl_be), 64'hFF);
      chk("reset_stats", rd_grant_count | wr_grant_count | stall_count, 0);
      do_reset();

      // Single read, one-cycle grant latency
      s_rd = rd_acks;
      exp_rd.push_back(26'h000100);
      bus.rd_addr = 26'h000100;
      bus.rd_req  = 1'b1;
      @(negedge ddr3_clk);
      chk("rd_latency_idle", bus.ddr3_avl_read_req, 0);
      @(negedge ddr3_clk);
      chk("rd_cmd", {bus.ddr3_avl_read_req, bus.ddr3_avl_burstbegin,
                     bus.ddr3_avl_addr}, {2'b11, 26'h000100});
      @(posedge ddr3_clk);
      #1;
      bus.rd_req = 1'b0;
      @(negedge ddr3_clk);
      chk("rd_back_idle", {bus.ddr3_avl_read_req, bus.rd_ack}, 0);
      repeat (2) @(negedge ddr3_clk);
      chk("rd_ack_once", rd_acks - s_rd, 1);
      @(posedge ddr3_clk);
      #1;

      // Write with two stall cycles on beat 1
      s_wr = wr_acks; s_wda = wda_cnt; s_bb = bb_cycles; s_d1 = d1_cycles;
      d1_val        = 64'hD000_0000_0000_0001;
      stall_wr_only = 1'b1;
      stall_budget  = 2;
      rdy_mode      = 2;
      wr_drive(1, 0, 64'hD000_0000_0000_0000);
      rdy_mode = 0;
      repeat (2) @(negedge ddr3_clk);
      chk("bp_d1_held", d1_cycles - s_d1, 3);
      chk("bp_data_acks", wda_cnt - s_wda, BL);
      chk("bp_wr_ack", wr_acks - s_wr, 1);
      chk("bp_burstbegin", bb_cycles - s_bb, 1);

      // Round-robin with both held: read first after reset, then alternate
      do_reset();
      for (int i = 0; i < 8; i++) exp_grant.push_back(i[0]);
      fork
         rd_drive(4, 0, 0);
         wr_drive(4, 0, 0);
      join
      repeat (3) @(posedge ddr3_clk);
      #1;
      chk("rr_grants_left", exp_grant.size(), 0);
      chk("rr_queues_left", exp_rd.size() + exp_wr.size(), 0);

      // Urgent reads against a held write: 8 reads, 1 write, repeat
      do_reset();
      for (int i = 0; i < 20; i++) exp_grant.push_back((i % (MAXR + 1)) == MAXR);
      fork
         rd_drive(18, 0, 1);
         wr_drive(2, 0, 0);
      join
      repeat (3) @(posedge ddr3_clk);
      #1;
      chk("urg_grants_left", exp_grant.size(), 0);
      chk("urg_queues_left", exp_rd.size() + exp_wr.size(), 0);

      // Asynchronous reset at beat 2 of a write
      s_wr = wr_acks;
      ma = AW'($urandom);
      for (int k = 0; k < BL; k++) begin
         mw[k] = {$urandom, $urandom};
         exp_wr.push_back('{ma, mw[k], k});
      end
      bus.wr_addr = ma;
      bus.wr_data = mw[0];
      bus.wr_req  = 1'b1;
      mb = 0;
      mt = 0;
      while (mb < 2 && mt < BOUND) begin
         @(negedge ddr3_clk);
         mt++;
         if (bus.wr_data_ack) begin
            @(posedge ddr3_clk);
            #1;
            mb++;
            bus.wr_data = mw[mb];
         end
      end
      if (mb < 2) fail("mid_timeout", "too few beats");
      @(negedge ddr3_clk);
      chk("mid_active", {bus.ddr3_avl_write_req, bus.ddr3_avl_burstbegin}, 2'b10);
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_cmd", {bus.ddr3_avl_read_req, bus.ddr3_avl_write_req,
                            bus.ddr3_avl_burstbegin, bus.rd_ack, bus.wr_ack,
                            bus.wr_data_ack}, 0);
      chk("async_rst_addr", 64'(bus.ddr3_avl_addr), 0);
      chk("async_rst_wdata", bus.ddr3_avl_wdata, 0);
      do_reset();
      chk("mid_no_wr_ack", wr_acks - s_wr, 0);
      exp_grant.push_back(1'b0);
      exp_grant.push_back(1'b1);
      fork
         rd_drive(1, 0, 0);
         wr_drive(1, 0, 0);
      join
      repeat (2) @(posedge ddr3_clk);
      #1;
      chk("post_rst_grants", exp_grant.size(), 0);

      // Statistics: 3 reads, 2 writes, 5 stalled command cycles
      do_reset();
      stall_wr_only = 1'b0;
      stall_budget  = 5;
      rdy_mode      = 2;
      rd_drive(3, 0, 0);
      wr_drive(2, 0, 0);
      rdy_mode = 0;
      repeat (2) @(negedge ddr3_clk);
      chk("stat_rd", rd_grant_count, STATS ? 3 : 0);
      chk("stat_wr", wr_grant_count, STATS ? 2 : 0);
      chk("stat_stall", stall_count, STATS ? 5 : 0);
      @(posedge ddr3_clk);
      #1;

      // Randomised traffic with random ready and urgency
      rdy_mode = 1;
      fork
         rd_drive(30, 3, 2);
         wr_drive(20, 4, 0);
      join
      rdy_mode = 0;
      repeat (4) @(posedge ddr3_clk);
      #1;
      chk("rand_rd_left", exp_rd.size(), 0);
      chk("rand_wr_left", exp_wr.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected summary");
      $fatal(1, "watchdog");
   end

endmodule
